// File: rtl/caliptra_fpga_apb_sequencer_if.sv
// Host request/response channel and APB master bus of the APB sequencer.
// slave = sequencer view; master = host plus APB slave environment view.
interface caliptra_fpga_apb_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int USER_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [2:0]        req_prot;
  logic [USER_W-1:0] req_user;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [2:0]        pprot;
  logic [USER_W-1:0] pauser;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_prot, req_user,
    input  rsp_ready, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pprot, pauser
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_prot, req_user,
    output rsp_ready, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pprot, pauser
  );
endinterface

// File: rtl/caliptra_fpga_apb_sequencer.sv
// One posted request -> APB SETUP/ACCESS with bounded PREADY wait -> held response; accept-to-rsp_valid >= 3 cycles.
// Single outstanding txn, response held until rsp_ready; CALIPTRA_FPGA_APB_TXN_COUNT_EN adds txn/err counters.
module caliptra_fpga_apb_sequencer #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int USER_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         aclk,
  input  logic                         rstn,
  caliptra_fpga_apb_sequencer_if.slave bus,
  output logic                         busy,
  output logic [31:0]                  txn_count,
  output logic [31:0]                  err_count
);

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              req_ready_q;
  logic              busy_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [2:0]        pprot_q;
  logic [USER_W-1:0] pauser_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  // Every output is a flop, so nothing on the request or PREADY side reaches the APB pins combinationally.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pprot_q       <= '0;
      pauser_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            state       <= SETUP;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            pwrite_q    <= bus.req_write;
            paddr_q     <= bus.req_addr;
            pwdata_q    <= bus.req_wdata;
            pprot_q     <= bus.req_prot;
            pauser_q    <= bus.req_user;
            wait_cnt    <= '0;
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
        end

        ACCESS: begin
          // PREADY on the final allowed cycle still counts as a normal completion.
          if (bus.pready) begin
            state         <= RESP;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
            rsp_err_q     <= bus.pslverr;
            rsp_timeout_q <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state         <= RESP;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            wait_cnt      <= wait_cnt + CNT_W'(1);
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            busy_q        <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pprot       = pprot_q;
  assign bus.pauser      = pauser_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign busy            = busy_q;

`ifdef CALIPTRA_FPGA_APB_TXN_COUNT_EN
  logic        rsp_hs;
  logic [31:0] txn_q;
  logic [31:0] err_q;

  // rsp_valid_q is only ever set in RESP, so this is exactly the response handshake.
  assign rsp_hs = rsp_valid_q && bus.rsp_ready;

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      txn_q <= '0;
      err_q <= '0;
    end else if (rsp_hs) begin
      txn_q <= txn_q + 32'd1;
      if (rsp_err_q) begin
        err_q <= err_q + 32'd1;
      end
    end
  end

  assign txn_count = txn_q;
  assign err_count = err_q;
`else
  assign txn_count = '0;
  assign err_count = '0;
`endif

endmodule
